// File: rtl/nrzi_line_encoder.sv
`timescale 1ns/1ps
// nrzi_line_encoder
// Multi-lane NRZ line encoder. Every lane shares one valid/ready handshake,
// and the encoded line levels are registered.
//   mode 0 : NRZ pass-through
//   mode 1 : NRZ-M / NRZI (the line toggles on a 1)
//   mode 2 : NRZ-S (the line toggles on a 0)
//   mode 3 : NRZI with all-lane bit stuffing and input backpressure
// Build option: NRZI_LINE_ENCODER_STUFF_EN builds the run counters and the
// stuff logic. When it is undefined, mode 3 encodes exactly like mode 1,
// in_ready is tied high and stuff_active is tied low.
module nrzi_line_encoder #(
    parameter int   LANES      = 4,
    parameter int   STUFF_LEN  = 6,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] In,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    output logic [LANES-1:0] Out,
    output logic             out_valid,
    output logic             stuff_active
);

    localparam logic [1:0] MODE_NRZ  = 2'd0;
    localparam logic [1:0] MODE_NRZM = 2'd1;
    localparam logic [1:0] MODE_NRZS = 2'd2;

    // The run counters are 4 bits wide, so the trigger length must fit in them.
    if (STUFF_LEN < 2 || STUFF_LEN > 15) begin : g_bad_stuff_len
        $error("nrzi_line_encoder: STUFF_LEN must lie in 2..15");
    end

    // Next line level for all lanes, given the mode sampled with the beat.
    function automatic logic [LANES-1:0] encode_line(
        input logic [1:0]       m,
        input logic [LANES-1:0] line,
        input logic [LANES-1:0] din
    );
        logic [LANES-1:0] res;
        case (m)
            MODE_NRZ:  res = din;
            MODE_NRZM: res = line ^ din;
            MODE_NRZS: res = line ^ ~din;
            default:   res = line ^ din;   // mode 3 uses the NRZI rule
        endcase
        return res;
    endfunction

    logic             rst_sync_q;
    logic             accept;
    logic [LANES-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    // Reset deassertion is retimed by one flop, so the first beat can be taken on the 2nd edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 1'b0;
        else        rst_sync_q <= 1'b1;
    end

    // A beat is consumed only once the retimed reset has released the datapath.
    assign accept = in_valid & in_ready & rst_sync_q;

`ifdef NRZI_LINE_ENCODER_STUFF_EN
    localparam logic [1:0] MODE_STUFF  = 2'd3;
    localparam logic [3:0] RUN_MAX     = 4'hF;
    localparam logic [3:0] STUFF_LEN_C = 4'(STUFF_LEN);

    // Run counters saturate, so a stuck lane cannot wrap back below the trigger.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == RUN_MAX) ? v : v + 4'd1;
    endfunction

    logic [LANES-1:0][3:0] run_q, run_d;
    logic                  stuff_pending_q, stuff_pending_d;
    logic [1:0]            last_mode_q;
    logic                  mode_change;
    logic                  stuff_hit;
    logic                  stuff_active_q, stuff_active_d;
    logic [3:0]            run_base;

    // The stuff cycle is the only time the encoder refuses input.
    assign in_ready    = ~stuff_pending_q;
    assign mode_change = (mode != last_mode_q);

    // Run-length tracking and stuff scheduling.
    always_comb begin
        run_d           = run_q;
        stuff_pending_d = stuff_pending_q;
        stuff_hit       = 1'b0;
        run_base        = 4'd0;
        if (stuff_pending_q) begin
            // The stuffed symbol is a transition on every lane, so every run restarts.
            run_d           = '0;
            stuff_pending_d = 1'b0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                // A mode change restarts counting before this beat is applied.
                run_base = mode_change ? 4'd0 : run_q[i];
                if (mode == MODE_STUFF) begin
                    run_d[i] = In[i] ? 4'd0 : sat_inc(run_base);
                end else begin
                    run_d[i] = run_base;
                end
                if (mode == MODE_STUFF && run_d[i] == STUFF_LEN_C) begin
                    stuff_hit = 1'b1;
                end
            end
            // Several lanes that hit together still share a single stuff cycle.
            stuff_pending_d = stuff_hit;
        end
    end

    // Counter, pending-stuff and last-mode state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q           <= '0;
            stuff_pending_q <= 1'b0;
            last_mode_q     <= MODE_NRZ;
        end else begin
            run_q           <= run_d;
            stuff_pending_q <= stuff_pending_d;
            if (accept) last_mode_q <= mode;
        end
    end

    // Line level: a stuff cycle forces a transition on all lanes; otherwise an accepted beat is encoded.
    always_comb begin
        out_d          = out_q;
        out_valid_d    = 1'b0;
        stuff_active_d = 1'b0;
        if (stuff_pending_q) begin
            out_d          = ~out_q;
            out_valid_d    = 1'b1;
            stuff_active_d = 1'b1;
        end else if (accept) begin
            out_d       = encode_line(mode, out_q, In);
            out_valid_d = 1'b1;
        end
    end

    // Registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q          <= {LANES{IDLE_LEVEL}};
            out_valid_q    <= 1'b0;
            stuff_active_q <= 1'b0;
        end else begin
            out_q          <= out_d;
            out_valid_q    <= out_valid_d;
            stuff_active_q <= stuff_active_d;
        end
    end

    assign stuff_active = stuff_active_q;
`else
    // Without stuffing the encoder never applies backpressure.
    assign in_ready = 1'b1;

    // Line level follows each accepted beat; it holds between beats.
    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (accept) begin
            out_d       = encode_line(mode, out_q, In);
            out_valid_d = 1'b1;
        end
    end

    // Registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= {LANES{IDLE_LEVEL}};
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign stuff_active = 1'b0;
`endif

    assign Out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nrzi_line_encoder.sv
`timescale 1ns/1ps
// Testbench for nrzi_line_encoder: a behavioural model checked every cycle,
// plus directed sequences with literal expected line levels.
module tb_nrzi_line_encoder;

    localparam int LANES     = 4;
    localparam int STUFF_LEN = 6;
`ifdef NRZI_LINE_ENCODER_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic [LANES-1:0] In       = '0;
    logic             in_valid = 1'b0;
    logic [1:0]       mode     = 2'd0;
    logic             in_ready;
    logic [LANES-1:0] Out;
    logic             out_valid;
    logic             stuff_active;

    always #5 clk = ~clk;

    nrzi_line_encoder #(
        .LANES      (LANES),
        .STUFF_LEN  (STUFF_LEN),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .In           (In),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mode         (mode),
        .Out          (Out),
        .out_valid    (out_valid),
        .stuff_active (stuff_active)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: line levels per lane, zero-run lengths as plain integers.
    bit [LANES-1:0] m_line = '0;
    int             m_run[LANES];
    bit             m_pend = 0;
    bit             m_ov   = 0;
    bit             m_sa   = 0;
    bit             m_en   = 0;
    int             m_last = 0;
    int             md;
    bit             counting;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_line = '0;
            for (int i = 0; i < LANES; i++) m_run[i] = 0;
            m_pend = 0; m_ov = 0; m_sa = 0; m_en = 0; m_last = 0;
        end else if (!m_en) begin
            m_en = 1; m_ov = 0; m_sa = 0;
        end else if (m_pend) begin
            m_line = ~m_line;
            for (int i = 0; i < LANES; i++) m_run[i] = 0;
            m_ov = 1; m_sa = 1; m_pend = 0;
        end else if (in_valid) begin
            md       = int'(mode);
            counting = STUFF && (md == 3);
            if (md == 3) md = 1;
            if (STUFF && int'(mode) != m_last)
                for (int i = 0; i < LANES; i++) m_run[i] = 0;
            for (int i = 0; i < LANES; i++) begin
                if (md == 0)      m_line[i] = In[i];
                else if (md == 1) m_line[i] = m_line[i] ^ In[i];
                else              m_line[i] = m_line[i] ^ !In[i];
                if (counting) m_run[i] = In[i] ? 0 : ((m_run[i] < 15) ? m_run[i] + 1 : 15);
            end
            m_last = int'(mode);
            if (counting)
                for (int i = 0; i < LANES; i++) if (m_run[i] == STUFF_LEN) m_pend = 1;
            m_ov = 1; m_sa = 0;
        end else begin
            m_ov = 0; m_sa = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    bit cmp_on = 0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_out",   32'(Out),          32'(m_line));
            chk("cyc_valid", 32'(out_valid),    32'(m_ov));
            chk("cyc_stuff", 32'(stuff_active), 32'(m_sa));
            chk("cyc_ready", 32'(in_ready),     32'(STUFF ? !m_pend : 1'b1));
        end
    end

    // Present one beat and hold it until it is accepted; returns just after the accepting edge.
    task automatic send(input logic [3:0] d, input logic [1:0] m);
        int tries;
        bit r;
        In = d; mode = m; in_valid = 1'b1; tries = 0;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!r && tries < 8);
        if (!r) chk("send_timeout", 32'(r), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] s_m1;
    logic [7:0] e_m1;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cmp_on = 1;
        chk("rst_out",   32'(Out),          32'(4'b0000));
        chk("rst_valid", 32'(out_valid),    32'(0));
        chk("rst_ready", 32'(in_ready),     32'(1));
        chk("rst_stuff", 32'(stuff_active), 32'(0));

        // Release: the first accept lands on the 2nd edge
        @(negedge clk);
        reset = 1'b1; In = 4'b0001; mode = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("edge1_valid", 32'(out_valid), 32'(0));
        chk("edge1_out",   32'(Out),       32'(4'b0000));
        @(posedge clk); #1;
        chk("edge2_valid", 32'(out_valid), 32'(1));
        chk("edge2_out",   32'(Out),       32'(4'b0001));

        // mode 1 on lane 0: 0,1,1,1,0,0,1,0 -> 0,1,0,1,1,1,0,0
        send(4'b0000, 2'd0);
        s_m1 = 8'b0100_1110;
        e_m1 = 8'b0011_1010;
        for (int k = 0; k < 8; k++) begin
            send({3'b000, s_m1[k]}, 2'd1);
            chk("m1_out", 32'(Out), 32'({3'b000, e_m1[k]}));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid", 32'(out_valid), 32'(0));
        chk("idle_hold",  32'(Out),       32'(4'b0000));

        // mode 2, In = 0101 for 3 beats
        send(4'b0101, 2'd2); chk("m2_b1", 32'(Out), 32'(4'b1010));
        send(4'b0101, 2'd2); chk("m2_b2", 32'(Out), 32'(4'b0000));
        send(4'b0101, 2'd2); chk("m2_b3", 32'(Out), 32'(4'b1010));

`ifdef NRZI_LINE_ENCODER_STUFF_EN
        // mode 3: six all-zero beats, then one stuff cycle, then the 7th beat
        send(4'b0000, 2'd0);
        for (int k = 0; k < 6; k++) begin
            send(4'b0000, 2'd3);
            chk("m3_zero_out", 32'(Out), 32'(4'b0000));
        end
        @(negedge clk);
        chk("m3_stall_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        chk("m3_stuff_out",   32'(Out),          32'(4'b1111));
        chk("m3_stuff_flag",  32'(stuff_active), 32'(1));
        chk("m3_stuff_valid", 32'(out_valid),    32'(1));
        @(negedge clk);
        chk("m3_beat7_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        chk("m3_beat7_out",   32'(Out),          32'(4'b1111));
        chk("m3_beat7_flag",  32'(stuff_active), 32'(0));
        chk("m3_beat7_valid", 32'(out_valid),    32'(1));

        // mode 3: lanes 0 and 2 reach the limit together -> one stuff cycle
        send(4'b1111, 2'd3);
        chk("m3_two_pre", 32'(Out), 32'(4'b0000));
        for (int k = 0; k < 6; k++) begin
            send(4'b1010, 2'd3);
            chk("m3_two_out", 32'(Out), 32'((k % 2 == 0) ? 4'b1010 : 4'b0000));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("m3_two_stall", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        chk("m3_two_stuff_out",  32'(Out),          32'(4'b1111));
        chk("m3_two_stuff_flag", 32'(stuff_active), 32'(1));
        @(negedge clk);
        chk("m3_two_once_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        chk("m3_two_once_flag",  32'(stuff_active), 32'(0));
        chk("m3_two_once_valid", 32'(out_valid),    32'(0));
`else
        // Without stuffing, mode 3 encodes like mode 1
        send(4'b0000, 2'd0);
        send(4'b0001, 2'd3); chk("m3_as_m1_b1", 32'(Out), 32'(4'b0001));
        send(4'b0001, 2'd3); chk("m3_as_m1_b2", 32'(Out), 32'(4'b0000));
        for (int k = 0; k < 7; k++) send(4'b0000, 2'd3);
        chk("m3_no_stall", 32'(in_ready), 32'(1));
`endif

        // Mode 3 -> 1 -> 3 after five zero-bits: the 6th zero-bit does not stuff
        send(4'b1111, 2'd0);
        chk("sw_pre", 32'(Out), 32'(4'b1111));
        for (int k = 0; k < 5; k++) begin
            send(4'b0000, 2'd3);
            chk("sw_run_out", 32'(Out), 32'(4'b1111));
        end
        send(4'b0000, 2'd1);
        chk("sw_m1_out", 32'(Out), 32'(4'b1111));
        send(4'b0000, 2'd3);
        chk("sw_6th_out",  32'(Out),          32'(4'b1111));
        chk("sw_6th_flag", 32'(stuff_active), 32'(0));
        in_valid = 1'b0;
        @(negedge clk);
        chk("sw_no_stall", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        chk("sw_no_stuff", 32'(stuff_active), 32'(0));
        chk("sw_no_valid", 32'(out_valid),    32'(0));

        // Reset while a stuff cycle is pending: the stuff symbol never appears
        send(4'b0000, 2'd0);
        for (int k = 0; k < 6; k++) send(4'b0000, 2'd3);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("rp_out",   32'(Out),          32'(4'b0000));
        chk("rp_valid", 32'(out_valid),    32'(0));
        chk("rp_flag",  32'(stuff_active), 32'(0));
        chk("rp_ready", 32'(in_ready),     32'(1));
        repeat (2) begin
            @(posedge clk); #1;
            chk("rp_hold_out",  32'(Out),          32'(4'b0000));
            chk("rp_hold_flag", 32'(stuff_active), 32'(0));
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        send(4'b0011, 2'd1);
        chk("rp_after_out", 32'(Out), 32'(4'b0011));

        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
